// File: rtl/dwc_pkg.sv
// Shared types and constants for the duplicate-with-compare feeder.
package dwc_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      WAIT_RESP = 2'd2,
      REPORT    = 2'd3
   } state_e;

   localparam int unsigned DATA_W_DEF = 32;

   localparam int unsigned SET_A = 0;
   localparam int unsigned SET_B = 1;
   localparam logic [1:0]  DATA_SET_FULL = 2'b11;

   // Round outcome reported alongside done.
   typedef struct packed {
      logic match;
      logic fault;
      logic timeout;
   } outcome_t;

endpackage

// File: rtl/dwc_timeout_ctr.sv
// Up-counter with clear/enable; expire_o is high while the count sits at LIMIT-1.
module dwc_timeout_ctr #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned   CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          expire_q;

   // Holds at LAST so an unattended counter never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         expire_q <= (LAST == '0);
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= (cnt_d == LAST);
      end
   end

   assign expire_o = expire_q;

endmodule

// File: rtl/dwc_feeder.sv
// Pairs one result word from each redundant core, arms the comparator and
// reports a one-cycle outcome, flagging hung cores or a silent comparator.
module dwc_feeder
   import dwc_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned PAIR_TIMEOUT = 1024,
   parameter int unsigned RESP_TIMEOUT = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b,
   output logic [1:0]        data_set,
   input  logic              isMatch,
   input  logic              interupt_prompt,
   output logic              done,
   output logic              match,
   output logic              fault,
   output logic              timeout,
   output logic [CNT_W-1:0]  mismatch_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_a_q, data_a_d;
   logic [DATA_W-1:0]   data_b_q, data_b_d;
   logic [1:0]          set_q, set_d;
   logic                a_ready_q, a_ready_d;
   logic                b_ready_q, b_ready_d;
   logic                guard_q, guard_d;
   logic                done_q, done_d;
   outcome_t            out_q, out_d;
   logic [CNT_W-1:0]    mm_cnt_q, mm_cnt_d;

   logic a_hs, b_hs;
   logic pair_exp, resp_exp;

   assign a_hs = a_valid & a_ready_q;
   assign b_hs = b_valid & b_ready_q;

   dwc_timeout_ctr #(.LIMIT(PAIR_TIMEOUT)) u_pair_ctr (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (state_q != COLLECT),
      .en_i     (state_q == COLLECT),
      .expire_o (pair_exp)
   );

   // Only sampled cycles count toward the verdict timeout.
   dwc_timeout_ctr #(.LIMIT(RESP_TIMEOUT)) u_resp_ctr (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (state_q != WAIT_RESP),
      .en_i     ((state_q == WAIT_RESP) && !guard_q),
      .expire_o (resp_exp)
   );

   always_comb begin
      state_d  = state_q;
      data_a_d = data_a_q;
      data_b_d = data_b_q;
      set_d    = set_q;
      out_d    = '0;
      mm_cnt_d = mm_cnt_q;

      unique case (state_q)
         IDLE, COLLECT: begin
            if (a_hs) begin
               data_a_d     = a_data;
               set_d[SET_A] = 1'b1;
            end
            if (b_hs) begin
               data_b_d     = b_data;
               set_d[SET_B] = 1'b1;
            end
            // A capture in the expiry cycle completes the pair.
            if (set_d == DATA_SET_FULL) begin
               state_d = WAIT_RESP;
            end else if (set_d != 2'b00) begin
               if ((state_q == COLLECT) && pair_exp) begin
                  state_d       = REPORT;
                  set_d         = 2'b00;
                  out_d.fault   = 1'b1;
                  out_d.timeout = 1'b1;
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         WAIT_RESP: begin
            // First cycle after arming may carry a verdict from the previous pair.
            if (!guard_q) begin
               if (interupt_prompt) begin
                  state_d     = REPORT;
                  out_d.fault = 1'b1;
               end else if (isMatch) begin
                  state_d     = REPORT;
                  out_d.match = 1'b1;
               end else if (resp_exp) begin
                  state_d       = REPORT;
                  out_d.fault   = 1'b1;
                  out_d.timeout = 1'b1;
               end
               if (state_d == REPORT) begin
                  set_d = 2'b00;
               end
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
      endcase

      if (out_d.fault && (mm_cnt_q != CNT_MAX)) begin
         mm_cnt_d = mm_cnt_q + CNT_W'(1);
      end
   end

   assign done_d    = (state_d == REPORT);
   assign guard_d   = (state_q != WAIT_RESP) && (state_d == WAIT_RESP);
   assign a_ready_d = ((state_d == IDLE) || (state_d == COLLECT)) && !set_d[SET_A];
   assign b_ready_d = ((state_d == IDLE) || (state_d == COLLECT)) && !set_d[SET_B];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         data_a_q  <= '0;
         data_b_q  <= '0;
         set_q     <= 2'b00;
         a_ready_q <= 1'b1;
         b_ready_q <= 1'b1;
         guard_q   <= 1'b0;
         done_q    <= 1'b0;
         out_q     <= '0;
         mm_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         set_q     <= set_d;
         a_ready_q <= a_ready_d;
         b_ready_q <= b_ready_d;
         guard_q   <= guard_d;
         done_q    <= done_d;
         out_q     <= out_d;
         mm_cnt_q  <= mm_cnt_d;
      end
   end

   assign a_ready      = a_ready_q;
   assign b_ready      = b_ready_q;
   assign data_a       = data_a_q;
   assign data_b       = data_b_q;
   assign data_set     = set_q;
   assign done         = done_q;
   assign match        = out_q.match;
   assign fault        = out_q.fault;
   assign timeout      = out_q.timeout;
   assign mismatch_cnt = mm_cnt_q;

endmodule

// File: tb/tb_dwc_feeder.sv
// Bench for dwc_feeder: each round's outcome and timing are derived from
// offer cycles and verdict delay with plain arithmetic, then checked per cycle.
module tb_dwc_feeder;

   localparam int unsigned DW   = 32;
   localparam int          PT   = 8;
   localparam int          RT   = 4;
   localparam int unsigned CW   = 2;
   localparam int          MMAX = 3;
   localparam int          INF  = 10000;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_valid, b_valid;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready;
   logic [DW-1:0] data_a, data_b;
   logic [1:0]    data_set;
   logic          isMatch, interupt_prompt;
   logic          done, match, fault, timeout;
   logic [CW-1:0] mismatch_cnt;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] prev_da, prev_db;
   int            mm;

   dwc_feeder #(
      .DATA_W(DW), .PAIR_TIMEOUT(PT), .RESP_TIMEOUT(RT), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .data_a(data_a), .data_b(data_b), .data_set(data_set),
      .isMatch(isMatch), .interupt_prompt(interupt_prompt),
      .done(done), .match(match), .fault(fault), .timeout(timeout),
      .mismatch_cnt(mismatch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ta/tb: cycle (1-based from round start) a core first offers; k: sampled
   // verdict cycle (k > RT means silent); kind: 0 match, 1 mismatch, 2 both.
   task automatic run_round(input logic [DW-1:0] da, input logic [DW-1:0] db,
                            input int ta, input int tb, input int k,
                            input int kind, input logic spur);
      int   e1, e2, ed, cap_a, cap_b, mm_new;
      logic pf, em, ef, et;
      e1 = (ta < tb) ? ta : tb;
      e2 = (ta < tb) ? tb : ta;
      if (e2 - e1 > PT) begin
         pf = 1'b1; ed = e1 + PT;
         cap_a = (ta == e1) ? ta : INF;
         cap_b = (tb == e1) ? tb : INF;
         em = 1'b0; ef = 1'b1; et = 1'b1;
      end else begin
         pf = 1'b0; cap_a = ta; cap_b = tb;
         if (k <= RT) begin
            ed = e2 + 1 + k; em = (kind == 0); ef = (kind != 0); et = 1'b0;
         end else begin
            ed = e2 + 1 + RT; em = 1'b0; ef = 1'b1; et = 1'b1;
         end
      end
      mm_new = (ef && mm < MMAX) ? mm + 1 : mm;

      for (int c = 1; c <= ed + 1; c++) begin
         int e;
         @(negedge clk);
         e = c - 1;
         chk("done", done, e == ed);
         chk("outcome", {match, fault, timeout}, (e == ed) ? {em, ef, et} : 3'b000);
         chk("a_ready", a_ready, (e < cap_a) && (e < ed));
         chk("b_ready", b_ready, (e < cap_b) && (e < ed));
         chk("data_set", data_set, (e < ed) ? {e >= cap_b, e >= cap_a} : 2'b00);
         chk("data_a", data_a, (e >= cap_a) ? da : prev_da);
         chk("data_b", data_b, (e >= cap_b) ? db : prev_db);
         chk("mismatch_cnt", mismatch_cnt, (e >= ed) ? mm_new : mm);

         // Offers stay up with junk data after capture to prove the stall.
         a_valid = (c >= ta) && (c <= ed);
         b_valid = (c >= tb) && (c <= ed);
         a_data  = (c == ta) ? da : $urandom;
         b_data  = (c == tb) ? db : $urandom;
         isMatch = 1'b0;
         interupt_prompt = 1'b0;
         if (!pf && c == e2 + 1) begin
            isMatch = spur;
            interupt_prompt = spur & 1'($urandom);
         end
         if (!pf && c >= e2 + 1 + k && c <= ed) begin
            isMatch         = (kind != 1);
            interupt_prompt = (kind != 0);
         end
      end
      if (cap_a <= ed) prev_da = da;
      if (cap_b <= ed) prev_db = db;
      mm = mm_new;
   endtask

   initial begin
      logic [DW-1:0] rd;
      reset = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
      isMatch = 1'b0; interupt_prompt = 1'b0;
      prev_da = '0; prev_db = '0; mm = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {a_ready, b_ready}, 2'b11);
      chk("rst_set", data_set, 2'b00);
      chk("rst_data", {data_a, data_b}, 64'h0);
      chk("rst_out", {done, match, fault, timeout, mismatch_cnt}, 6'h0);
      reset = 1'b0;

      run_round(32'd5, 32'd5, 3, 4, 1, 0, 1'b0);
      run_round(32'hDEAD_BEEF, 32'hDEAD_BEEE, 1, 1, 1, 1, 1'b0);
      run_round(32'd7, 32'd0, 1, INF, 1, 0, 1'b0);
      run_round(32'h11, 32'h11, 2, 2, 100, 0, 1'b1);
      run_round(32'h22, 32'h23, 1, 2, 2, 2, 1'b1);
      run_round(32'h33, 32'h33, 1, 1 + PT, 1, 0, 1'b0);
      run_round(32'h44, 32'h44, 2, 3 + PT, 1, 0, 1'b0);
      run_round(32'h55, 32'h55, 2, 1, RT, 0, 1'b1);

      // Asynchronous reset while core A's word is held.
      @(negedge clk);
      a_valid = 1'b1; a_data = 32'd9;
      @(negedge clk);
      a_valid = 1'b0;
      chk("mid_set", data_set, 2'b01);
      chk("mid_ready", {a_ready, b_ready}, 2'b01);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_set", data_set, 2'b00);
      chk("arst_ready", {a_ready, b_ready}, 2'b11);
      chk("arst_out", {done, mismatch_cnt, data_a}, 35'h0);
      @(negedge clk);
      reset = 1'b0;
      prev_da = '0; prev_db = '0; mm = 0;
      run_round(32'hA5A5_0001, 32'hA5A5_0001, 1, 2, 1, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int ta, tb, r;
         rd = $urandom;
         ta = $urandom_range(1, 3);
         r  = $urandom_range(0, 9);
         tb = (r == 0) ? INF : ta + $urandom_range(0, PT + 1);
         if ($urandom_range(0, 1) == 1 && tb != INF) begin
            r = ta; ta = tb; tb = r;
         end
         run_round(rd, ($urandom_range(0, 1) == 1) ? rd : $urandom, ta, tb,
                   $urandom_range(1, RT + 2), $urandom_range(0, 2), 1'($urandom));
      end

      // Fault runs to drive the narrow counter into saturation.
      for (int i = 0; i < 5; i++) begin
         run_round(32'h1, 32'h2, 1, 1, 1, 2, 1'b0);
      end
      @(negedge clk);
      chk("sat_cnt", mismatch_cnt, 2'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
